systolic_array_is_ctrl: RTL

Sequencer for the input-stationary systolic array `systolic_array_is`. It accepts a job start, loads ARRAY_HEIGHT input rows through a valid/ready stream while asserting `input_en`, then streams weight columns while asserting `process_en`. It tags each issued column and realigns the returned partial sums into a valid-qualified result stream, then signals completion. It sits between the buffer/DMA layer and the array instance.

---
 rtl/systolic_array_is_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_is_ctrl.sv
// systolic_array_is_ctrl: job sequencer for the input-stationary systolic array.
// Loads ARRAY_HEIGHT input rows, streams weight columns, and realigns the
// returned partial sums into a valid-qualified result stream.
// Optional feature macro: SA_IS_CTRL_PERF_EN (adds perf_cycles / perf_stalls).
module systolic_array_is_ctrl #(
  parameter int unsigned INPUT_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH  = 16,
  parameter int unsigned PSUM_WIDTH    = 32,
  parameter int unsigned ARRAY_HEIGHT  = 4,
  parameter int unsigned ARRAY_WIDTH   = 4,
  parameter int unsigned COL_CNT_WIDTH = 8,
  parameter int unsigned PSUM_LATENCY  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [COL_CNT_WIDTH-1:0]              cfg_num_cols,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]   in_data,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]   w_data,
  output logic                                  input_en,
  output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]   input_out,
  output logic                                  process_en,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]   weight_out,
  input  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]     psum_in,
  output logic                                  psum_valid,
  output logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]     psum_out
`ifdef SA_IS_CTRL_PERF_EN
  ,
  output logic [31:0]                           perf_cycles,
  output logic [31:0]                           perf_stalls
`endif
);

  localparam int unsigned IN_BUS_W = ARRAY_HEIGHT * INPUT_WIDTH;
  localparam int unsigned W_BUS_W  = ARRAY_WIDTH * WEIGHT_WIDTH;
  localparam int unsigned P_BUS_W  = ARRAY_WIDTH * PSUM_WIDTH;
  localparam int unsigned IN_CNT_W = $clog2(ARRAY_HEIGHT + 1);
  localparam int unsigned TAG_W    = PSUM_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     in_ready_q, in_ready_d;
  logic                     w_ready_q, w_ready_d;
  logic                     input_en_q, input_en_d;
  logic                     process_en_q, process_en_d;
  logic                     psum_valid_q, psum_valid_d;
  logic [IN_BUS_W-1:0]      input_out_q, input_out_d;
  logic [W_BUS_W-1:0]       weight_out_q, weight_out_d;
  logic [P_BUS_W-1:0]       psum_out_q, psum_out_d;
  logic [COL_CNT_WIDTH-1:0] cols_q, cols_d;
  logic [COL_CNT_WIDTH-1:0] w_cnt_q, w_cnt_d;
  logic [IN_CNT_W-1:0]      in_cnt_q, in_cnt_d;
  logic [TAG_W-1:0]         tag_q, tag_d;

  logic in_hs, w_hs, in_last, w_last, drained, start_acc;

  assign start_acc = (state_q == S_IDLE) && start;
  assign in_hs     = in_valid && in_ready_q;
  assign w_hs      = w_valid && w_ready_q;
  assign in_last   = in_hs && (in_cnt_q == IN_CNT_W'(ARRAY_HEIGHT - 1));
  assign w_last    = w_hs && (w_cnt_q == (cols_q - COL_CNT_WIDTH'(1)));
  // The beat currently on process_en has not reached the tag register yet.
  assign drained   = (tag_q == '0) && !process_en_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_acc) state_d = S_LOAD;
      S_LOAD:   if (in_last) state_d = (cols_q == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (w_last) state_d = S_DRAIN;
      S_DRAIN:  if (drained) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered control outputs decoded from the upcoming state
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    in_ready_d = (state_d == S_LOAD);
    w_ready_d  = (state_d == S_STREAM);
  end

  // Datapath: job counters, beat capture, tag shift register, result realignment
  always_comb begin
    cols_d       = cols_q;
    in_cnt_d     = in_cnt_q;
    w_cnt_d      = w_cnt_q;
    input_en_d   = 1'b0;
    input_out_d  = input_out_q;
    process_en_d = 1'b0;
    weight_out_d = weight_out_q;
    psum_valid_d = 1'b0;
    psum_out_d   = psum_out_q;
    tag_d        = (tag_q << 1) | TAG_W'(process_en_q);
    if (start_acc) begin
      cols_d   = cfg_num_cols;
      in_cnt_d = '0;
      w_cnt_d  = '0;
    end
    if (in_hs) begin
      in_cnt_d    = in_cnt_q + IN_CNT_W'(1);
      input_en_d  = 1'b1;
      input_out_d = in_data;
    end
    if (w_hs) begin
      w_cnt_d      = w_cnt_q + COL_CNT_WIDTH'(1);
      process_en_d = 1'b1;
      weight_out_d = w_data;
    end
    if (tag_q[TAG_W-1]) begin
      psum_valid_d = 1'b1;
      psum_out_d   = psum_in;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      w_ready_q    <= 1'b0;
      input_en_q   <= 1'b0;
      process_en_q <= 1'b0;
      psum_valid_q <= 1'b0;
      input_out_q  <= '0;
      weight_out_q <= '0;
      psum_out_q   <= '0;
      cols_q       <= '0;
      in_cnt_q     <= '0;
      w_cnt_q      <= '0;
      tag_q        <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      in_ready_q   <= in_ready_d;
      w_ready_q    <= w_ready_d;
      input_en_q   <= input_en_d;
      process_en_q <= process_en_d;
      psum_valid_q <= psum_valid_d;
      input_out_q  <= input_out_d;
      weight_out_q <= weight_out_d;
      psum_out_q   <= psum_out_d;
      cols_q       <= cols_d;
      in_cnt_q     <= in_cnt_d;
      w_cnt_q      <= w_cnt_d;
      tag_q        <= tag_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign in_ready   = in_ready_q;
  assign w_ready    = w_ready_q;
  assign input_en   = input_en_q;
  assign input_out  = input_out_q;
  assign process_en = process_en_q;
  assign weight_out = weight_out_q;
  assign psum_valid = psum_valid_q;
  assign psum_out   = psum_out_q;

`ifdef SA_IS_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating busy-cycle and weight-stall counters, cleared per job
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (start_acc) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == S_STREAM) && !w_valid && (perf_stalls_q != '1))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
